// File: rtl/pipe_out_fifo.sv
//==============================================================================
// pipe_out_fifo : FWFT output buffer absorbing consumer back-pressure behind
//                 a non-stallable pipeline; almost_full early warning and
//                 sticky overflow flag.                          Rev 1.0
//==============================================================================
`default_nettype none

module pipe_out_fifo #(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 8,
   parameter int AF_MARGIN = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     almost_full,
   output logic                     overflow,
   input  logic                     clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             ovf;
   logic             push;
   logic             pop;
   logic             drop;

   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign pop  = out_valid && out_ready;
   assign push = in_valid && ((cnt < FULL_CNT) || pop);
   assign drop = in_valid && !push;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            cnt <= cnt + 1'b1;
         end else if (pop && !push) begin
            cnt <= cnt - 1'b1;
         end
         // Set wins over clear so a drop is never lost.
         if (drop) begin
            ovf <= 1'b1;
         end else if (clr_ovf) begin
            ovf <= 1'b0;
         end
      end
   end

   assign out_valid   = (cnt != '0);
   assign out_data    = mem[rd_ptr];
   assign count       = cnt;
   assign almost_full = (cnt >= AF_CNT);
   assign overflow    = ovf;

endmodule

`default_nettype wire

// File: tb/tb_pipe_out_fifo.sv
//==============================================================================
// tb_pipe_out_fifo : directed self-checking bench for pipe_out_fifo.  Rev 1.0
//==============================================================================
`default_nettype none

module tb_pipe_out_fifo;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [3:0] count;
   logic       almost_full;
   logic       overflow;
   logic       clr_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_out_fifo #(.DEPTH(8), .WIDTH(8), .AF_MARGIN(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .count       (count),
      .almost_full (almost_full),
      .overflow    (overflow),
      .clr_ovf     (clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(out_valid),   32'd0);
      check({tag, "_count"}, 32'(count),       32'd0);
      check({tag, "_af"},    32'(almost_full), 32'd0);
      check({tag, "_ovf"},   32'(overflow),    32'd0);
      check({tag, "_data"},  32'(out_data),    32'd0);
   endtask

   logic [7:0] exp_q[$];
   logic [7:0] drain_exp[9];
   logic       af_prev;
   int         sent;
   int         got_n;
   int         cyc;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      #12;
      check_reset_outputs("reset");
      tick();
      rst_n = 1'b1;
      tick();

      // Stream 0x01..0x10 straight through
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         in_data = 8'(i);
         tick();
         check("stream_data",  32'(out_data),  32'(i));
         check("stream_count", 32'(count),     32'd1);
         check("stream_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      tick();
      check("stream_end_count", 32'(count),    32'd0);
      check("stream_end_ovf",   32'(overflow), 32'd0);

      // Fill with back-pressure
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = 8'hA0 + 8'(i);
         tick();
         check("fill_count", 32'(count),       32'(i + 1));
         check("fill_af",    32'(almost_full), (i + 1 >= 5) ? 32'd1 : 32'd0);
      end

      // Overflow: drop while full, then clear with and without a drop
      in_data = 8'hFF;
      tick();
      check("ovf_set",   32'(overflow), 32'd1);
      check("ovf_count", 32'(count),    32'd8);
      check("ovf_head",  32'(out_data), 32'hA0);
      clr_ovf = 1'b1;
      tick();
      check("ovf_clr_with_drop", 32'(overflow), 32'd1);
      in_valid = 1'b0;
      tick();
      check("ovf_clr", 32'(overflow), 32'd0);
      clr_ovf = 1'b0;

      // Full with simultaneous push and pop
      check("full_head", 32'(out_data), 32'hA0);
      in_valid  = 1'b1;
      in_data   = 8'h55;
      out_ready = 1'b1;
      tick();
      check("pp_count", 32'(count),    32'd8);
      check("pp_ovf",   32'(overflow), 32'd0);
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) drain_exp[i] = 8'hA1 + 8'(i);
      drain_exp[7] = 8'h55;
      for (int i = 0; i < 8; i++) begin
         check("drain_valid", 32'(out_valid), 32'd1);
         check("drain_data",  32'(out_data),  32'(drain_exp[i]));
         tick();
      end
      check("drain_count", 32'(count),     32'd0);
      check("drain_empty", 32'(out_valid), 32'd0);

      // Wrap-around with random back-pressure, upstream gated by delayed almost_full
      sent    = 0;
      got_n   = 0;
      cyc     = 0;
      af_prev = 1'b0;
      while (got_n < 24 && cyc < 2000) begin
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (sent < 24) && !af_prev;
         in_data   = 8'($urandom);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("wrap_unexpected_pop", 32'(out_data), 32'hDEAD);
            end else begin
               check("wrap_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            got_n++;
         end
         if (in_valid) begin
            exp_q.push_back(in_data);
            sent++;
         end
         af_prev = almost_full;
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("wrap_received", 32'(got_n),    32'd24);
      check("wrap_ovf",      32'(overflow), 32'd0);
      check("wrap_count",    32'(count),    32'd0);

      // Mid-operation asynchronous reset
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 8'h10 + 8'(i);
         tick();
      end
      in_valid = 1'b0;
      check("pre_rst_count", 32'(count), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      tick();
      rst_n = 1'b1;
      tick();
      in_valid = 1'b1;
      in_data  = 8'h3C;
      tick();
      in_valid = 1'b0;
      check("post_rst_data",  32'(out_data), 32'h3C);
      check("post_rst_count", 32'(count),    32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_out_fifo.md
# pipe_out_fifo

Output buffer that sits directly downstream of the 8-bit three-stage nonblocking register pipeline. It captures each pipeline word tagged valid, holds it in a small FIFO, and presents it to a consumer through a valid/ready handshake. The pipeline itself cannot stall, so this block absorbs consumer back-pressure. It raises an early-warning `almost_full` sized to cover the pipeline's three cycles of in-flight data, and flags any word dropped on overflow.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, minimum 4.
- `WIDTH`, 8: data width; matches the pipeline width.
- `AF_MARGIN`, 3: free-slot threshold for `almost_full`; equals the pipeline depth.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  pipeline output word is valid; a valid sideband delayed alongside the data.
- `in_data`  in  WIDTH  pipeline output word (`q3` of the upstream pipeline).
- `out_valid`  out  1  FIFO holds at least one word.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `out_data`  out  WIDTH  head-of-FIFO word.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `almost_full`  out  1  asserted when `count >= DEPTH - AF_MARGIN`.
- `overflow`  out  1  sticky flag: a valid word was dropped.
- `clr_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- Storage: `DEPTH` x `WIDTH` register array.
  - Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo `DEPTH` naturally.
  - `count` is a separate registered counter.
- push = `in_valid` && (`count` < `DEPTH` || pop).
- pop = `out_valid` && `out_ready`.
- On push:
  - `mem[wr_ptr]` <= `in_data`.
  - `wr_ptr` increments.
- On pop: `rd_ptr` increments.
- `count` update:
  - push only: +1.
  - pop only: −1.
  - both, or neither: unchanged.
- Full with simultaneous pop: push is accepted, `count` stays at `DEPTH`, and no overflow occurs.
- Full with no pop:
  - The word is dropped.
  - No pointer or `count` change.
  - `overflow` sets.
- Empty with `in_valid`:
  - The word is written; no pop is possible because `out_valid` = 0.
  - `count` becomes 1 on the next cycle.
- `out_data` = `mem[rd_ptr]`, which is first-word-fall-through. When `out_valid` = 0 its value is don't-care, but it must be stable (no X after reset; the array resets to 0).
- `out_valid` = (`count` != 0), decoded from the registered `count`.
- `almost_full` is a combinational decode of the registered `count`.
- `overflow` behaviour:
  - Set has priority over clear: a drop in the same cycle as `clr_ovf` leaves it set.
  - Otherwise `clr_ovf` clears it on the next edge.
- The block applies no flow control upstream. The upstream source must stop issuing within one cycle of seeing `almost_full`. With `AF_MARGIN` = 3, the three words in flight still fit.
- Reset (`rst_n` low, asynchronous, any time including mid-transfer):
  - Pointers, `count`, `overflow` and the array are cleared immediately.
  - Hence `out_valid` = 0, `count` = 0, `almost_full` = 0, `overflow` = 0, `out_data` = 0.
  - Stored words are discarded.
  - Operation resumes on the first rising edge after `rst_n` deasserts.

## Timing
- Input to output latency: one cycle. A word with `in_valid` at edge N appears as `out_valid`/`out_data` after edge N, usable at edge N+1.
- End-to-end from the pipeline input `d`: 4 cycles.
- Throughput: one push and one pop per cycle, sustained indefinitely while `out_ready` = 1.
- A pop at edge N exposes the next word immediately after edge N.
- All outputs except `out_data` are registered or decoded from registered state only. No combinational path runs from `out_ready` or `in_valid` to any output.

## Test plan
- Reset then stream: after `rst_n` release, drive 0x01..0x10 with `in_valid` = 1 and `out_ready` = 1.
  - Required: identical sequence on `out_data`, each word one cycle after input.
  - `count` toggles between 0 and 1 only; `overflow` = 0.
- Fill and drain: `out_ready` = 0, push 0xA0..0xA7 (DEPTH = 8).
  - `count` = 8.
  - `almost_full` first high when `count` = 5.
  - Then `out_ready` = 1: 0xA0..0xA7 emerge in order and `count` returns to 0.
- Overflow: while full with `out_ready` = 0, push 0xFF.
  - `overflow` = 1, `count` stays 8, and 0xFF never appears on the output.
  - `clr_ovf` pulse clears the flag; a drop in the same cycle as `clr_ovf` keeps it at 1.
- Full with simultaneous push/pop: at `count` = 8, `in_valid` = 1 (0x55) and `out_ready` = 1.
  - `count` stays 8 and `overflow` = 0.
  - 0x55 emerges after the earlier 7 words.
- Wrap-around: 3×DEPTH words with random `out_ready` (~50%) and back-to-back `in_valid` gated by `almost_full` at 1-cycle delay.
  - Output equals input order, with no drops and no overflow.
- Mid-operation reset: with `count` = 5, assert `rst_n` low between clock edges.
  - All outputs go to their reset values immediately, without waiting for `clk`.
  - After release, the first pushed word 0x3C is the first word out.
